// File: rtl/aes128_hardened_decrypt.sv
// Iterative AES-128 inverse cipher: round keys are derived backward from rk10 on the fly.
// Optional temporal-redundancy fault detection is enabled with `define AES_DEC_FAULT_DETECT_EN.
module aes128_hardened_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  input  logic         inject_fault,
  input  logic [3:0]   fault_round_sel,
  input  logic [6:0]   fault_bit_sel,
  output logic [127:0] plaintext,
  output logic         valid,
  output logic         busy,
  output logic         fault_alert
);

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL, DONE, FAULT} fsm_t;

  fsm_t         fsm, fsm_next;
  logic [127:0] ct_q, rk_q, blk_q;
  logic [3:0]   cnt_q;
  logic [127:0] rk_prev, step_out;
  logic         step_done, step_bad;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, t;
    acc = 8'h00;
    t   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ t;
      t = xtime(t);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one schedule step: recover w3..w1 by XOR, then w0 from the recovered w3.
  function automatic logic [127:0] key_bwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    int src;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
      t[127 - 8*i -: 8] = inv_sbox(s[127 - 8*src -: 8]);
    end
    t = t ^ rk;
    if (!last)
      for (int c = 0; c < 4; c++)
        t[127 - 32*c -: 32] = inv_mix_col(t[127 - 32*c -: 32]);
    return t;
  endfunction

  assign rk_prev  = key_bwd(rk_q, rcon(cnt_q + 4'd1));
  assign step_out = inv_round(blk_q, rk_prev, fsm == FINAL);
  assign busy     = (fsm != IDLE);

`ifdef AES_DEC_FAULT_DETECT_EN
  logic         phase_q, inj_q, alert_q;
  logic [3:0]   fr_q;
  logic [6:0]   fb_q;
  logic [127:0] prim_q, flip;

  assign flip        = (inj_q && fr_q == cnt_q) ? (128'd1 << fb_q) : '0;
  assign step_done   = phase_q;
  assign step_bad    = phase_q && (prim_q != step_out);
  assign fault_alert = alert_q;
`else
  logic unused_fault_inputs;
  assign unused_fault_inputs = ^{inject_fault, fault_round_sel, fault_bit_sel};
  assign step_done   = 1'b1;
  assign step_bad    = 1'b0;
  assign fault_alert = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (start) fsm_next = KEYEXP;
      KEYEXP:  if (cnt_q == 4'd9) fsm_next = ADDKEY;
      ADDKEY:  fsm_next = ROUND;
      ROUND:   if (step_bad) fsm_next = FAULT;
               else if (step_done && cnt_q == 4'd1) fsm_next = FINAL;
      FINAL:   if (step_bad) fsm_next = FAULT;
               else if (step_done) fsm_next = DONE;
      DONE:    fsm_next = IDLE;
      FAULT:   fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // cnt_q counts key-schedule steps in KEYEXP, then holds the round index r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_q      <= '0;
      rk_q      <= '0;
      blk_q     <= '0;
      cnt_q     <= '0;
      plaintext <= '0;
      valid     <= 1'b0;
`ifdef AES_DEC_FAULT_DETECT_EN
      phase_q   <= 1'b0;
      inj_q     <= 1'b0;
      alert_q   <= 1'b0;
      fr_q      <= '0;
      fb_q      <= '0;
      prim_q    <= '0;
`endif
    end else begin
      valid <= (fsm == DONE);
      case (fsm)
        IDLE: if (start) begin
          ct_q  <= ciphertext;
          rk_q  <= key;
          cnt_q <= 4'd0;
`ifdef AES_DEC_FAULT_DETECT_EN
          phase_q <= 1'b0;
          inj_q   <= inject_fault;
          fr_q    <= fault_round_sel;
          fb_q    <= fault_bit_sel;
          alert_q <= 1'b0;
`endif
        end
        KEYEXP: begin
          rk_q  <= key_fwd(rk_q, rcon(cnt_q + 4'd1));
          cnt_q <= cnt_q + 4'd1;
        end
        ADDKEY: begin
          blk_q <= ct_q ^ rk_q;
          cnt_q <= 4'd9;
        end
        ROUND, FINAL: begin
`ifdef AES_DEC_FAULT_DETECT_EN
          // First pass stores the (possibly corrupted) result; second pass recomputes and compares.
          if (!phase_q) begin
            prim_q  <= step_out ^ flip;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (prim_q != step_out) begin
              plaintext <= '0;
              alert_q   <= 1'b1;
            end else begin
              if (fsm == ROUND) blk_q <= prim_q;
              else              plaintext <= prim_q;
              rk_q  <= rk_prev;
              cnt_q <= cnt_q - 4'd1;
            end
          end
`else
          if (fsm == ROUND) blk_q <= step_out;
          else              plaintext <= step_out;
          rk_q  <= rk_prev;
          cnt_q <= cnt_q - 4'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_hardened_decrypt.sv
// Self-checking bench for aes128_hardened_decrypt: known-answer table, randomized runs
// against an array-based AES model, and hand-written timing/fault/reset sequences.
module tb_aes128_hardened_decrypt;

`ifdef AES_DEC_FAULT_DETECT_EN
  localparam int LAT = 32;
`else
  localparam int LAT = 22;
`endif
  localparam int WAIT_LIMIT = 80;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ciphertext, key;
  logic         inject_fault;
  logic [3:0]   fault_round_sel;
  logic [6:0]   fault_bit_sel;
  logic [127:0] plaintext;
  logic         valid, busy, fault_alert;

  int vectors_applied = 0;
  int miscompares     = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];
  logic [7:0] rc_tab [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [3];

  aes128_hardened_decrypt dut (
    .clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext), .key(key),
    .inject_fault(inject_fault), .fault_round_sel(fault_round_sel),
    .fault_bit_sel(fault_bit_sel), .plaintext(plaintext), .valid(valid),
    .busy(busy), .fault_alert(fault_alert)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input int n);
    logic [7:0] x2, x4, x8;
    x2 = xt(a); x4 = xt(x2); x8 = xt(x4);
    case (n)
      9:       return x8 ^ a;
      11:      return x8 ^ x2 ^ a;
      13:      return x8 ^ x4 ^ a;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  // S-box built by walking the generator 3 and its inverse in lockstep.
  task automatic buildTables();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
    rc_tab[0] = 8'h00;
    rc_tab[1] = 8'h01;
    for (int j = 2; j < 11; j++) rc_tab[j] = xt(rc_tab[j-1]);
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] c);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [127:0] st, rk;
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0)
        tmp = {sbox_t[tmp[23:16]] ^ rc_tab[i/4], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]};
      w[i] = w[i-4] ^ tmp;
    end
    st = c ^ {w[40], w[41], w[42], w[43]};
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) b[i] = st[127 - 8*i -: 8];
      for (int rr = 0; rr < 4; rr++)
        for (int cc = 0; cc < 4; cc++)
          t[rr + 4*((cc + rr) % 4)] = isbox_t[b[rr + 4*cc]];
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ rk[127 - 8*i -: 8];
      if (r > 0)
        for (int cc = 0; cc < 4; cc++) begin
          for (int i = 0; i < 4; i++) b[i] = t[4*cc + i];
          t[4*cc+0] = gmul(b[0],14) ^ gmul(b[1],11) ^ gmul(b[2],13) ^ gmul(b[3],9);
          t[4*cc+1] = gmul(b[0],9)  ^ gmul(b[1],14) ^ gmul(b[2],11) ^ gmul(b[3],13);
          t[4*cc+2] = gmul(b[0],13) ^ gmul(b[1],9)  ^ gmul(b[2],14) ^ gmul(b[3],11);
          t[4*cc+3] = gmul(b[0],11) ^ gmul(b[1],13) ^ gmul(b[2],9)  ^ gmul(b[3],14);
        end
      for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = t[i];
    end
    return st;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one start pulse; returns 1ns after the edge that sampled it.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c, input logic inj,
                               input logic [3:0] rs, input logic [6:0] bs);
    key = k; ciphertext = c; inject_fault = inj; fault_round_sel = rs; fault_bit_sel = bs;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitValid(input int first, output int cycles, output logic seen);
    cycles = first;
    seen = 1'b0;
    while (!seen && cycles < WAIT_LIMIT) begin
      @(posedge clk); #1;
      cycles++;
      if (valid) seen = 1'b1;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [127:0] k, input logic [127:0] c,
                             input logic inj, input logic [3:0] rs, input logic [6:0] bs,
                             input logic [127:0] exp_pt);
    int cyc;
    logic seen;
    @(negedge clk);
    applyStimulus(k, c, inj, rs, bs);
    checkOutput({name, " busy"}, 128'(busy), 128'(1));
    waitValid(0, cyc, seen);
    checkOutput({name, " latency"}, 128'(cyc), 128'(LAT));
    checkOutput({name, " plaintext"}, plaintext, exp_pt);
    checkOutput({name, " fault_alert"}, 128'(fault_alert), 128'(0));
    @(posedge clk); #1;
    checkOutput({name, " valid pulse width"}, 128'(valid), 128'(0));
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [127:0] rk, rc, exp_pt;
    logic rinj;
    logic [3:0] rrs;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    buildTables();

    rst = 1'b1; start = 1'b0; key = '0; ciphertext = '0;
    inject_fault = 1'b0; fault_round_sel = '0; fault_bit_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset plaintext", plaintext, 128'h0);
    checkOutput("reset valid", 128'(valid), 128'(0));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset fault_alert", 128'(fault_alert), 128'(0));
    @(negedge clk); rst = 1'b0;

    $display("[TB] known-answer vectors");
    for (int i = 0; i < 3; i++)
      runAndCheck($sformatf("kat%0d", i), vecs[i].key, vecs[i].ct, 1'b0, 4'd0, 7'd0, vecs[i].pt);

    $display("[TB] randomized vectors against model");
    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rc = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_DEC_FAULT_DETECT_EN
      rinj = 1'b1;
      rrs  = 4'(10 + $urandom_range(0, 5));
`else
      rinj = 1'($urandom);
      rrs  = 4'($urandom);
`endif
      runAndCheck($sformatf("rand%0d", i), rk, rc, rinj, rrs, 7'($urandom), model_decrypt(rk, rc));
    end

    $display("[TB] back-to-back start in the valid cycle");
    @(negedge clk);
    applyStimulus(vecs[1].key, vecs[1].ct, 1'b0, 4'd0, 7'd0);
    waitValid(0, cyc, seen);
    checkOutput("b2b first plaintext", plaintext, vecs[1].pt);
    applyStimulus(vecs[0].key, vecs[0].ct, 1'b0, 4'd0, 7'd0);
    waitValid(0, cyc, seen);
    checkOutput("b2b second latency", 128'(cyc), 128'(LAT));
    checkOutput("b2b second plaintext", plaintext, vecs[0].pt);

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    applyStimulus(vecs[1].key, vecs[1].ct, 1'b0, 4'd0, 7'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("busy at cycle 5", 128'(busy), 128'(1));
    applyStimulus(vecs[0].key, 128'hdeadbeef_00000000_12345678_9abcdef0, 1'b1, 4'd3, 7'd9);
    waitValid(5, cyc, seen);
    checkOutput("ignored start latency", 128'(cyc), 128'(LAT));
    checkOutput("ignored start plaintext", plaintext, vecs[1].pt);

    $display("[TB] reset in the middle of an operation");
    @(negedge clk);
    applyStimulus(vecs[1].key, vecs[1].ct, 1'b0, 4'd0, 7'd0);
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midreset plaintext", plaintext, 128'h0);
    checkOutput("midreset valid", 128'(valid), 128'(0));
    checkOutput("midreset busy", 128'(busy), 128'(0));
    checkOutput("midreset fault_alert", 128'(fault_alert), 128'(0));
    @(negedge clk); rst = 1'b0;
    waitValid(0, cyc, seen);
    checkOutput("midreset no valid", 128'(seen), 128'(0));
    runAndCheck("post-reset kat0", vecs[0].key, vecs[0].ct, 1'b0, 4'd0, 7'd0, vecs[0].pt);

`ifdef AES_DEC_FAULT_DETECT_EN
    $display("[TB] fault injection");
    for (int i = 0; i < 4; i++) begin
      rrs = (i == 0) ? 4'd5 : 4'($urandom_range(0, 9));
      @(negedge clk);
      applyStimulus(vecs[1].key, vecs[1].ct, 1'b1, rrs, (i == 0) ? 7'd0 : 7'($urandom));
      waitValid(0, cyc, seen);
      checkOutput($sformatf("fault%0d no valid", i), 128'(seen), 128'(0));
      checkOutput($sformatf("fault%0d alert", i), 128'(fault_alert), 128'(1));
      checkOutput($sformatf("fault%0d plaintext", i), plaintext, 128'h0);
      checkOutput($sformatf("fault%0d busy", i), 128'(busy), 128'(0));
      runAndCheck($sformatf("clean after fault%0d", i), vecs[1].key, vecs[1].ct,
                  1'b0, 4'd0, 7'd0, vecs[1].pt);
    end
    exp_pt = vecs[1].pt;
    runAndCheck("round_sel 12", vecs[1].key, vecs[1].ct, 1'b1, 4'd12, 7'd0, exp_pt);
`else
    $display("[TB] fault inputs ignored");
    runAndCheck("inject ignored", vecs[1].key, vecs[1].ct, 1'b1, 4'd5, 7'd0, vecs[1].pt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
